ov7670_capture_core: RTL

OV7670_CAPTURE_CORE -- requirements
Module: ov7670_capture_core

---
 rtl/ov7670_capture_core.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ov7670_capture_core.sv
// OV7670 parallel camera capture: synchronises the camera bus, frames on VS/HS,
// assembles byte pairs into pixels with optional decimation and error flags.
module ov7670_capture_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned H_WIDTH    = 640,
  parameter int unsigned V_WIDTH    = 480,
  parameter int unsigned PXL_WIDTH  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_n_reset,
  input  logic                        i_start,
  input  logic                        i_abort,
  input  logic                        i_continuous,
  input  logic [1:0]                  i_scale,
  input  logic                        i_fmt,
  input  logic                        i_PCLK,
  input  logic                        i_VS,
  input  logic                        i_HS,
  input  logic [DATA_WIDTH-1:0]       i_DATA,
  output logic [PXL_WIDTH-1:0]        o_pixel_data,
  output logic [$clog2(H_WIDTH):0]    o_h_addr,
  output logic [$clog2(V_WIDTH):0]    o_v_addr,
  output logic                        o_valid,
  output logic                        o_frame_done,
  output logic                        o_busy,
  output logic [2:0]                  o_state,
  output logic [7:0]                  o_frame_cnt,
  output logic [1:0]                  o_err
);

  localparam int unsigned HW = $clog2(H_WIDTH) + 1;
  localparam int unsigned VW = $clog2(V_WIDTH) + 1;
  localparam logic [HW-1:0] H_MAX = HW'(H_WIDTH);
  localparam logic [VW-1:0] V_MAX = VW'(V_WIDTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_VS = 3'd1,
    SYNC    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_e;

  // Camera strobes: two synchroniser stages plus one history stage for edges
  logic [2:0]            pclk_sh_q, pclk_sh_d;
  logic [2:0]            vs_sh_q, vs_sh_d;
  logic [2:0]            hs_sh_q, hs_sh_d;
  logic [DATA_WIDTH-1:0] data_m_q, data_m_d;
  logic [DATA_WIDTH-1:0] data_s_q, data_s_d;

  state_e                state_q, state_d;
  logic [HW-1:0]         h_q, h_d;
  logic [VW-1:0]         v_q, v_d;
  logic                  phase_q, phase_d;
  logic [DATA_WIDTH-1:0] first_q, first_d;
  logic                  cont_q, cont_d;
  logic [1:0]            scale_q, scale_d;
  logic                  fmt_q, fmt_d;
  logic                  valid_q, valid_d;
  logic [PXL_WIDTH-1:0]  pix_q, pix_d;
  logic [HW-1:0]         haddr_q, haddr_d;
  logic [VW-1:0]         vaddr_q, vaddr_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic [7:0]            fcnt_q, fcnt_d;
  logic [1:0]            err_q, err_d;

  logic                  pclk_rise;
  logic                  vs_rise, vs_fall;
  logic                  hs_rise, hs_fall, hs_level;
  logic                  on_grid;
  logic [PXL_WIDTH-1:0]  pix_word;

  assign pclk_rise = pclk_sh_q[1] & ~pclk_sh_q[2];
  assign vs_rise   = vs_sh_q[1] & ~vs_sh_q[2];
  assign vs_fall   = ~vs_sh_q[1] & vs_sh_q[2];
  assign hs_rise   = hs_sh_q[1] & ~hs_sh_q[2];
  assign hs_fall   = ~hs_sh_q[1] & hs_sh_q[2];
  assign hs_level  = hs_sh_q[1];

  always_comb begin
    pclk_sh_d = {pclk_sh_q[1:0], i_PCLK};
    vs_sh_d   = {vs_sh_q[1:0], i_VS};
    hs_sh_d   = {hs_sh_q[1:0], i_HS};
    data_m_d  = i_DATA;
    data_s_d  = data_m_q;
  end

  // Decimation grid: keep only pixels whose source coordinates are multiples of 2^scale
  always_comb begin
    case (scale_q)
      2'd0:    on_grid = 1'b1;
      2'd1:    on_grid = ~h_q[0] & ~v_q[0];
      default: on_grid = (h_q[1:0] == 2'b00) && (v_q[1:0] == 2'b00);
    endcase
  end

  assign pix_word = fmt_q ? PXL_WIDTH'(first_q) : PXL_WIDTH'({first_q, data_s_q});

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    phase_d = phase_q;
    first_d = first_q;
    cont_d  = cont_q;
    scale_d = scale_q;
    fmt_d   = fmt_q;
    valid_d = 1'b0;
    pix_d   = pix_q;
    haddr_d = haddr_q;
    vaddr_d = vaddr_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          state_d = WAIT_VS;
          err_d   = 2'b00;
        end
      end
      WAIT_VS: begin
        if (vs_rise) state_d = SYNC;
      end
      SYNC: begin
        if (vs_fall) begin
          state_d = CAPTURE;
          h_d     = '0;
          v_d     = '0;
          phase_d = 1'b0;
          cont_d  = i_continuous;
          scale_d = (i_scale == 2'd3) ? 2'd2 : i_scale;
          fmt_d   = i_fmt;
        end
      end
      CAPTURE: begin
        if (vs_rise) begin
          state_d = DONE;
        end else if (hs_rise) begin
          h_d     = '0;
          phase_d = 1'b0;
        end else if (hs_fall) begin
          // A lone first byte at end of line can never become a pixel
          if (phase_q) begin
            phase_d  = 1'b0;
            err_d[0] = 1'b1;
          end
          if ((h_q != '0) && (v_q < V_MAX)) v_d = v_q + VW'(1);
        end else if (pclk_rise && hs_level) begin
          if (!phase_q) begin
            first_d = data_s_q;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if ((h_q >= H_MAX) || (v_q >= V_MAX)) begin
              err_d[1] = 1'b1;
            end else if (on_grid) begin
              valid_d = 1'b1;
              pix_d   = pix_word;
              haddr_d = h_q >> scale_q;
              vaddr_d = v_q >> scale_q;
            end
            if (h_q < H_MAX) h_d = h_q + HW'(1);
          end
        end
      end
      DONE: begin
        state_d = cont_q ? SYNC : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (i_abort) begin
      state_d = IDLE;
      h_d     = '0;
      v_d     = '0;
      phase_d = 1'b0;
      valid_d = 1'b0;
    end

    done_d = (state_d == DONE);
    fcnt_d = done_d ? fcnt_q + 8'd1 : fcnt_q;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_n_reset) begin
    if (!i_n_reset) begin
      pclk_sh_q <= '0;
      vs_sh_q   <= '0;
      hs_sh_q   <= '0;
      data_m_q  <= '0;
      data_s_q  <= '0;
      state_q   <= IDLE;
      h_q       <= '0;
      v_q       <= '0;
      phase_q   <= 1'b0;
      first_q   <= '0;
      cont_q    <= 1'b0;
      scale_q   <= 2'd0;
      fmt_q     <= 1'b0;
      valid_q   <= 1'b0;
      pix_q     <= '0;
      haddr_q   <= '0;
      vaddr_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      fcnt_q    <= 8'd0;
      err_q     <= 2'b00;
    end else begin
      pclk_sh_q <= pclk_sh_d;
      vs_sh_q   <= vs_sh_d;
      hs_sh_q   <= hs_sh_d;
      data_m_q  <= data_m_d;
      data_s_q  <= data_s_d;
      state_q   <= state_d;
      h_q       <= h_d;
      v_q       <= v_d;
      phase_q   <= phase_d;
      first_q   <= first_d;
      cont_q    <= cont_d;
      scale_q   <= scale_d;
      fmt_q     <= fmt_d;
      valid_q   <= valid_d;
      pix_q     <= pix_d;
      haddr_q   <= haddr_d;
      vaddr_q   <= vaddr_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      fcnt_q    <= fcnt_d;
      err_q     <= err_d;
    end
  end

  assign o_pixel_data = pix_q;
  assign o_h_addr     = haddr_q;
  assign o_v_addr     = vaddr_q;
  assign o_valid      = valid_q;
  assign o_frame_done = done_q;
  assign o_busy       = busy_q;
  assign o_state      = state_q;
  assign o_frame_cnt  = fcnt_q;
  assign o_err        = err_q;

endmodule
